alu_nibble_sequencer: RTL and testbench

Multi-cycle controller that performs WIDTH-bit unsigned add, subtract, compare and pass operations by sequencing the team's 4-bit combinational ALU slice, one nibble per clock, LSB first, chaining carry/borrow between nibbles. It sits between a valid/ready request source and a single ALU instance, which the parent module instantiates alongside it. It owns the ALU's control inputs and returns one registered response per request.

---
 rtl/alu_seq_pkg.sv | 11 +
 rtl/alu_nibble_sequencer_if.sv | 23 ++
 rtl/alu_slice4.sv | 22 ++
 rtl/alu_nibble_sequencer.sv | 92 +++++++++
 tb/tb_alu_nibble_sequencer.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared ALU control codes, request op encodings and sequencer FSM states
package alu_seq_pkg;
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_CMP  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// alu_nibble_sequencer_if: request/response handshake bundle between a source/consumer and the sequencer
interface alu_nibble_sequencer_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_cin;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_carry;
  logic [1:0]   rsp_cmp;
  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_cmp
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_cmp
  );
endinterface

// File: rtl/alu_slice4.sv
// alu_slice4: 4-bit combinational ALU slice (pass, add with carry, subtract with borrow)
module alu_slice4 import alu_seq_pkg::*; (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [2:0] control_i,
  input  logic       c_in_i,
  input  logic       b_in_i,
  output logic [3:0] c_o,
  output logic       c_out_o,
  output logic       b_out_o
);
  logic [4:0] sum;
  logic [4:0] dif;
  assign sum = {1'b0, a_i} + {1'b0, b_i} + {4'b0, c_in_i};
  assign dif = {1'b0, a_i} - {1'b0, b_i} - {4'b0, b_in_i};
  // Select the result for the active control code; unknown codes yield zero
  always_comb begin
    c_o     = control_i == ALU_ADD ? sum[3:0] : control_i == ALU_SUB ? dif[3:0] : control_i == ALU_PASS ? a_i : 4'h0;
    c_out_o = control_i == ALU_ADD && sum[4];
    b_out_o = control_i == ALU_SUB && dif[4];
  end
endmodule

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs W-bit add/sub/compare/pass through an external 4-bit ALU, one nibble per clock
module alu_nibble_sequencer import alu_seq_pkg::*; #(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_nibble_sequencer_if.slave bus,
  output logic [3:0]            alu_a_o,
  output logic [3:0]            alu_b_o,
  output logic [2:0]            alu_control_o,
  output logic                  alu_c_in_o,
  output logic                  alu_b_in_o,
  input  logic [3:0]            alu_c_i,
  input  logic                  alu_c_out_i,
  input  logic                  alu_b_out_i
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          chain_q, chain_d;
  logic          done;
  assign done          = state_q == DONE;
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = done;
  assign bus.rsp_data  = res_q;
  assign bus.rsp_carry = done && op_q != OP_PASS && chain_q;
  assign bus.rsp_cmp   = done && op_q == OP_CMP ? {!chain_q && |res_q, chain_q} : 2'b00;
  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      chain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      chain_q <= chain_d;
    end
  end
  // Next state, nibble capture and ALU drive; ALU inputs idle at zero outside RUN
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    res_d         = res_q;
    idx_d         = idx_q;
    chain_d       = chain_q;
    alu_a_o       = 4'h0;
    alu_b_o       = 4'h0;
    alu_control_o = ALU_PASS;
    alu_c_in_o    = 1'b0;
    alu_b_in_o    = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        op_d    = bus.req_op;
        a_d     = bus.req_a;
        b_d     = bus.req_b;
        res_d   = '0;
        idx_d   = '0;
        chain_d = (bus.req_op == OP_ADD || bus.req_op == OP_SUB) && bus.req_cin;
        state_d = RUN;
      end
      RUN: begin
        alu_a_o       = a_q[4*idx_q +: 4];
        alu_b_o       = b_q[4*idx_q +: 4];
        alu_control_o = op_q == OP_ADD ? ALU_ADD : op_q == OP_PASS ? ALU_PASS : ALU_SUB;
        alu_c_in_o    = op_q == OP_ADD && chain_q;
        alu_b_in_o    = (op_q == OP_SUB || op_q == OP_CMP) && chain_q;
        res_d[4*idx_q +: 4] = alu_c_i;
        chain_d       = alu_control_o == ALU_SUB ? alu_b_out_i : alu_c_out_i;
        idx_d         = idx_q + 1'b1;
        if (idx_q == IW'(NIBBLES - 1)) state_d = DONE;
      end
      DONE: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer: directed bench with an arithmetic reference model and a per-cycle response monitor
module tb_alu_nibble_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  alu_a, alu_b, alu_c;
  logic [2:0]  alu_control;
  logic        alu_c_in, alu_b_in, alu_c_out, alu_b_out;
  int          checks = 0;
  int          failures = 0;
  logic [18:0] exp_q[$];
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [18:0] prev_rsp = '0;
  alu_nibble_sequencer_if #(.NIBBLES(4)) bus();
  alu_nibble_sequencer #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_control_o(alu_control),
    .alu_c_in_o(alu_c_in), .alu_b_in_o(alu_b_in),
    .alu_c_i(alu_c), .alu_c_out_i(alu_c_out), .alu_b_out_i(alu_b_out)
  );
  alu_slice4 u_alu (
    .a_i(alu_a), .b_i(alu_b), .control_i(alu_control), .c_in_i(alu_c_in), .b_in_i(alu_b_in),
    .c_o(alu_c), .c_out_o(alu_c_out), .b_out_o(alu_b_out)
  );
  always #5 clk = ~clk;
  // Expected {data, carry, cmp} from plain 17-bit arithmetic on the whole operands
  function automatic logic [18:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic [1:0]  cmp;
    s   = op == 2'd0 ? a + b + cin : op == 2'd1 ? {1'b0, a} - b - cin : op == 2'd2 ? {1'b0, a} - b : {1'b0, a};
    cmp = op == 2'd2 ? {a > b, a < b} : 2'b00;
    return {s[15:0], op != 2'd3 && s[16], cmp};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Monitor: scoreboard of accepted requests, response compare and stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
        chk("hold_rsp", {13'b0, bus.rsp_data, bus.rsp_carry, bus.rsp_cmp}, {13'b0, prev_rsp});
      end
      chk("ready_vs_valid", {31'b0, bus.req_ready && bus.rsp_valid}, 32'd0);
      if (bus.rsp_valid) begin
        chk("rsp_expected", {31'b0, exp_q.size() > 0}, 32'd1);
        chk("alu_idle_done", {19'b0, alu_a, alu_b, alu_control, alu_c_in, alu_b_in}, 32'd0);
        if (exp_q.size() > 0) begin
          chk("mdl_rsp", {13'b0, bus.rsp_data, bus.rsp_carry, bus.rsp_cmp}, {13'b0, exp_q[0]});
          if (bus.rsp_ready) exp_q.delete(0);
        end
      end
      if (bus.req_valid && bus.req_ready) exp_q.push_back(model(bus.req_op, bus.req_a, bus.req_b, bus.req_cin));
      pv = bus.rsp_valid;
      pr = bus.rsp_ready;
      prev_rsp = {bus.rsp_data, bus.rsp_carry, bus.rsp_cmp};
    end
  end
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin);
    int n = 0;
    while (!bus.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_cin = cin;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_a = 16'hDEAD;
    bus.req_b = 16'hBEEF;
  endtask
  task automatic finish(input string name, input logic [15:0] ed, input logic ec, input logic [1:0] ecmp);
    int n = 0;
    while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({name, "_latency"}, n, 32'd4);
    chk({name, "_data"}, {16'b0, bus.rsp_data}, {16'b0, ed});
    chk({name, "_carry"}, {31'b0, bus.rsp_carry}, {31'b0, ec});
    chk({name, "_cmp"}, {30'b0, bus.rsp_cmp}, {30'b0, ecmp});
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({name, "_drop"}, {31'b0, bus.rsp_valid}, 32'd0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = 2'd0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_cin = 1'b0;
    bus.rsp_ready = 1'b0;
    #1;
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_rsp", {12'b0, bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_cmp}, 32'd0);
    chk("rst_alu", {19'b0, alu_a, alu_b, alu_control, alu_c_in, alu_b_in}, 32'd0);
    chk("mdl_pin_add", {13'b0, model(2'd0, 16'h1234, 16'h0FFF, 1'b0)}, {13'b0, 16'h2233, 1'b0, 2'b00});
    chk("mdl_pin_cmp", {13'b0, model(2'd2, 16'h8000, 16'h7FFF, 1'b1)}, {13'b0, 16'h0001, 1'b0, 2'b10});
    chk("mdl_pin_sub", {13'b0, model(2'd1, 16'h0000, 16'h0001, 1'b0)}, {13'b0, 16'hFFFF, 1'b1, 2'b00});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'd0, 16'h1234, 16'h0FFF, 1'b0); finish("add1", 16'h2233, 1'b0, 2'b00);
    issue(2'd0, 16'hFFFF, 16'h0001, 1'b0); finish("add_ovf", 16'h0000, 1'b1, 2'b00);
    issue(2'd0, 16'h0000, 16'h0000, 1'b1); finish("add_cin", 16'h0001, 1'b0, 2'b00);
    issue(2'd1, 16'h1000, 16'h0001, 1'b0); finish("sub1", 16'h0FFF, 1'b0, 2'b00);
    issue(2'd1, 16'h0000, 16'h0001, 1'b0); finish("sub_brw", 16'hFFFF, 1'b1, 2'b00);
    issue(2'd1, 16'h0005, 16'h0003, 1'b1); finish("sub_bin", 16'h0001, 1'b0, 2'b00);
    issue(2'd2, 16'h1234, 16'h1235, 1'b1); finish("cmp_lt", 16'hFFFF, 1'b1, 2'b01);
    issue(2'd2, 16'hABCD, 16'hABCD, 1'b0); finish("cmp_eq", 16'h0000, 1'b0, 2'b00);
    issue(2'd2, 16'h8000, 16'h7FFF, 1'b0); finish("cmp_gt", 16'h0001, 1'b0, 2'b10);
    issue(2'd3, 16'h5A5A, 16'hFFFF, 1'b1); finish("pass", 16'h5A5A, 1'b0, 2'b00);
    issue(2'd0, 16'h1111, 16'h2222, 1'b0);
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) begin @(posedge clk); #1; end
    bus.req_valid = 1'b1;
    bus.req_op = 2'd1;
    bus.req_a = 16'h0010;
    bus.req_b = 16'h0001;
    bus.req_cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
      chk("bp_data", {15'b0, bus.rsp_valid, bus.rsp_data}, {15'b0, 1'b1, 16'h3333});
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("bp_back_idle", {30'b0, bus.req_ready, bus.rsp_valid}, 32'd2);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    finish("bp_second", 16'h000F, 1'b0, 2'b00);
    issue(2'd0, 16'h4444, 16'h1111, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("abort_alu", {19'b0, alu_a, alu_b, alu_control, alu_c_in, alu_b_in}, 32'd0);
    chk("abort_ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("abort_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    issue(2'd0, 16'h00FF, 16'h0001, 1'b0); finish("post_rst", 16'h0100, 1'b0, 2'b00);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
